// File: rtl/snn_fc_vote_sequencer.sv
// snn_fc_vote_sequencer: runs the FC classifier engine once per spike time
// step, tallies the per-step argmax class and reports the majority class.
// Optional build macro SNN_SEQ_WATCHDOG_EN adds a WAIT-state watchdog that
// aborts the inference with error=1, result=8'hFF after TIMEOUT cycles.
module snn_fc_vote_sequencer #(
  parameter int unsigned NUM_STEPS   = 8,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned STEP_STRIDE = 507,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT     = 8191
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] vec_base,
  input  logic [ADDR_W-1:0] weight_base,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result,
  output logic              error,
  output logic              fc_reset,
  output logic              fc_start,
  output logic [ADDR_W-1:0] fc_src1_start_address,
  output logic [ADDR_W-1:0] fc_src2_start_address,
  input  logic              fc_done,
  input  logic [7:0]        fc_result
);

  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WaitMax = WCW'(TIMEOUT);
`ifdef SNN_SEQ_WATCHDOG_EN
  localparam logic [WCW-1:0] WaitLast = WCW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ENG_RST, S_ENG_START, S_WAIT, S_TALLY, S_DECIDE, S_FIN
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        result_q;
  logic              fc_reset_q;
  logic              fc_start_q;
  logic [ADDR_W-1:0] src1_q;
  logic [ADDR_W-1:0] src2_q;
  logic [7:0]        step_q;
  logic [7:0]        cls_q;
  logic [WCW-1:0]    wait_cnt_q;
  logic [7:0]        votes_q [NUM_CLASSES];
  logic [7:0]        scan_idx_q;
  logic [7:0]        best_idx_q;
  logic [7:0]        best_cnt_q;
  logic [7:0]        scan_votes_c;
`ifdef SNN_SEQ_WATCHDOG_EN
  logic              error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign result                = result_q;
  assign fc_reset              = fc_reset_q;
  assign fc_start              = fc_start_q;
  assign fc_src1_start_address = src1_q;
  assign fc_src2_start_address = src2_q;

  // Vote count of the class currently under the DECIDE scan.
  always_comb begin
    scan_votes_c = '0;
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      if (scan_idx_q == 8'(i)) scan_votes_c = votes_q[i];
    end
  end

  // Sequencer FSM with registered outputs; single-cycle strobes default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      fc_reset_q <= 1'b0;
      fc_start_q <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      step_q     <= '0;
      cls_q      <= '0;
      wait_cnt_q <= '0;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      for (int i = 0; i < int'(NUM_CLASSES); i++) votes_q[i] <= '0;
`ifdef SNN_SEQ_WATCHDOG_EN
      error_q    <= 1'b0;
`endif
    end else begin
      fc_reset_q <= 1'b0;
      fc_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src1_q     <= vec_base;
            src2_q     <= weight_base;
            step_q     <= '0;
            result_q   <= '0;
            busy_q     <= 1'b1;
            fc_reset_q <= 1'b1;
            for (int i = 0; i < int'(NUM_CLASSES); i++) votes_q[i] <= '0;
`ifdef SNN_SEQ_WATCHDOG_EN
            error_q    <= 1'b0;
`endif
            state_q    <= S_ENG_RST;
          end
        end
        S_ENG_RST: begin
          fc_start_q <= 1'b1;
          wait_cnt_q <= '0;
          state_q    <= S_ENG_START;
        end
        S_ENG_START: state_q <= S_WAIT;
        S_WAIT: begin
          // The first WAIT cycle ignores fc_done so a stale level is never taken.
          if (wait_cnt_q != WaitMax) wait_cnt_q <= wait_cnt_q + WCW'(1);
          if ((wait_cnt_q != '0) && fc_done) begin
            cls_q   <= fc_result;
            state_q <= S_TALLY;
          end
`ifdef SNN_SEQ_WATCHDOG_EN
          else if (wait_cnt_q == WaitLast) begin
            error_q    <= 1'b1;
            result_q   <= 8'hFF;
            fc_reset_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_FIN;
          end
`endif
        end
        S_TALLY: begin
          for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            if ((cls_q == 8'(i)) && (votes_q[i] != 8'hFF)) votes_q[i] <= votes_q[i] + 8'd1;
          end
          step_q <= step_q + 8'd1;
          src1_q <= src1_q + ADDR_W'(STEP_STRIDE);
          if (step_q == 8'(NUM_STEPS - 1)) begin
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            state_q    <= S_DECIDE;
          end else begin
            fc_reset_q <= 1'b1;
            state_q    <= S_ENG_RST;
          end
        end
        S_DECIDE: begin
          // Strictly-greater compare keeps the lowest index on ties.
          if (scan_votes_c > best_cnt_q) begin
            best_cnt_q <= scan_votes_c;
            best_idx_q <= scan_idx_q;
          end
          scan_idx_q <= scan_idx_q + 8'd1;
          if (scan_idx_q == 8'(NUM_CLASSES - 1)) begin
            result_q <= (scan_votes_c > best_cnt_q) ? scan_idx_q : best_idx_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_fc_vote_sequencer.sv
// Directed bench for snn_fc_vote_sequencer with a latency-programmable FC
// engine model. Define SNN_SEQ_WATCHDOG_EN to exercise the watchdog build.
module tb_snn_fc_vote_sequencer;

`ifdef SNN_SEQ_WATCHDOG_EN
  localparam int unsigned TB_TIMEOUT = 50;
`else
  localparam int unsigned TB_TIMEOUT = 8191;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] vec_base;
  logic [11:0] weight_base;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic        error;
  logic        fc_reset;
  logic        fc_start;
  logic [11:0] fc_src1_start_address;
  logic [11:0] fc_src2_start_address;
  logic        fc_done;
  logic [7:0]  fc_result;

  int n_chk = 0;
  int n_err = 0;

  // Engine model controls and state.
  logic       eng_clr;
  int         eng_lat;
  int         eng_cnt;
  logic       eng_done;
  logic [7:0] eng_res_q;
  logic [7:0] eng_res [8];
  logic [2:0] eng_n;
  logic [2:0] eng_cur;
  logic       force_done;
  logic [7:0] force_res;

  // Monitor state.
  logic [11:0] addr_log [16];
  logic [3:0]  addr_n;
  int          done_cnt = 0;

  snn_fc_vote_sequencer #(
    .NUM_STEPS(8), .NUM_CLASSES(10), .STEP_STRIDE(507), .ADDR_W(12), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .vec_base(vec_base), .weight_base(weight_base),
    .busy(busy), .done(done), .result(result), .error(error),
    .fc_reset(fc_reset), .fc_start(fc_start),
    .fc_src1_start_address(fc_src1_start_address),
    .fc_src2_start_address(fc_src2_start_address),
    .fc_done(fc_done), .fc_result(fc_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fc_done   = eng_done | force_done;
  assign fc_result = force_done ? force_res : eng_res_q;

  // FC engine model: done rises eng_lat edges after fc_start (0 = never).
  always @(posedge clk) begin
    if (eng_clr) begin
      eng_n <= '0; eng_cur <= '0; eng_cnt <= 0; eng_done <= 1'b0; eng_res_q <= '0;
    end else if (fc_reset) begin
      eng_cnt <= 0; eng_done <= 1'b0;
    end else if (fc_start) begin
      eng_cnt <= eng_lat; eng_cur <= eng_n; eng_n <= eng_n + 3'd1;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done  <= 1'b1;
        eng_res_q <= eng_res[eng_cur];
      end
    end
  end

  // Log the step address at every engine start and count done pulses.
  always @(posedge clk) begin
    if (eng_clr) addr_n <= '0;
    else if (fc_start) begin
      addr_log[addr_n] <= fc_src1_start_address;
      addr_n <= addr_n + 4'd1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [63:0] v);
    for (int k = 0; k < 8; k++) eng_res[k] = v[63-8*k -: 8];
  endtask

  task automatic clr_engine();
    eng_clr = 1'b1;
    @(negedge clk);
    eng_clr = 1'b0;
  endtask

  // Start an inference and count cycles until done; optionally poke start mid-run.
  task automatic run(input logic [11:0] vb, input logic [11:0] wb, input int budget,
                     input int poke, output int cyc);
    vec_base = vb; weight_base = wb; start = 1'b1; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("fc_reset_step0", fc_reset, 1);
      end
      if (cyc == 2) begin
        chk("fc_start_step0", fc_start, 1);
        chk("fc_src2", fc_src2_start_address, wb);
      end
      if (cyc == poke) begin
        start = 1'b1;
        vec_base = 12'd55;
      end
    end while (!done && cyc < budget);
    chk("done_within_budget", done, 1);
  endtask

  initial begin
    int cyc;
    int d0;
    reset = 1'b1; start = 1'b0; vec_base = '0; weight_base = '0;
    eng_clr = 1'b1; eng_lat = 20; force_done = 1'b0; force_res = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; eng_clr = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_error", error, 0);
    chk("rst_fc_reset", fc_reset, 0);
    chk("rst_fc_start", fc_start, 0);
    chk("rst_src1", fc_src1_start_address, 0);
    chk("rst_src2", fc_src2_start_address, 0);

    // Happy path with address progression from vec_base=100.
    load({8'd3, 8'd3, 8'd7, 8'd3, 8'd1, 8'd3, 8'd7, 8'd3});
    eng_lat = 20;
    d0 = done_cnt;
    run(12'd100, 12'h3A5, 400, 0, cyc);
    chk("happy_latency", cyc, 203);
    chk("happy_result", result, 3);
    chk("happy_error", error, 0);
    chk("happy_busy_at_done", busy, 0);
    for (int k = 0; k < 8; k++) chk("happy_step_addr", addr_log[k], (100 + 507 * k) % 4096);
    @(negedge clk);
    chk("happy_done_single", done, 0);
    chk("happy_done_count", done_cnt - d0, 1);
    chk("happy_result_held", result, 3);

    // Ties resolve low, class 12 casts no vote, address wraps, start during busy ignored.
    clr_engine();
    load({8'd2, 8'd5, 8'd2, 8'd5, 8'd9, 8'd9, 8'd12, 8'd12});
    eng_lat = 5;
    d0 = done_cnt;
    run(12'd4000, 12'd0, 200, 30, cyc);
    chk("tie_latency", cyc, 83);
    chk("tie_result", result, 2);
    chk("wrap_addr_step0", addr_log[0], 4000);
    chk("wrap_addr_step1", addr_log[1], 411);
    chk("tie_addr_count", addr_n, 8);
    @(negedge clk);
    chk("tie_done_count", done_cnt - d0, 1);

    // No valid votes at all gives class 0.
    clr_engine();
    load({8{8'd12}});
    eng_lat = 1;
    run(12'd0, 12'd0, 200, 0, cyc);
    chk("zero_latency", cyc, 51);
    chk("zero_result", result, 0);

    // Winner is the last class in the scan.
    clr_engine();
    load({8'd9, 8'd9, 8'd9, 8'd0, 8'd0, 8'd1, 8'd2, 8'd9});
    eng_lat = 3;
    run(12'd0, 12'd0, 200, 0, cyc);
    chk("last_latency", cyc, 67);
    chk("last_result", result, 9);

    // fc_done held high across runs: only taken in the second WAIT cycle.
    clr_engine();
    eng_lat = 0;
    force_res = 8'd6;
    force_done = 1'b1;
    @(negedge clk);
    run(12'd0, 12'd0, 200, 0, cyc);
    chk("stale_latency", cyc, 51);
    chk("stale_result", result, 6);
    force_done = 1'b0;
    @(negedge clk);

`ifdef SNN_SEQ_WATCHDOG_EN
    // Engine never completes: watchdog aborts after 50 WAIT cycles.
    clr_engine();
    eng_lat = 0;
    run(12'd0, 12'd7, 200, 0, cyc);
    chk("wd_latency", cyc, 53);
    chk("wd_error", error, 1);
    chk("wd_result", result, 255);
    chk("wd_fc_reset", fc_reset, 1);
    @(negedge clk);
    chk("wd_fc_reset_pulse", fc_reset, 0);
    chk("wd_error_held", error, 1);
`else
    // Engine never completes: WAIT holds indefinitely with no error.
    clr_engine();
    eng_lat = 0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    chk("hang_busy", busy, 1);
    chk("hang_no_done", done_cnt - d0, 0);
    chk("hang_error", error, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("hang_reset_busy", busy, 0);
`endif

    // Reset in the WAIT of step 4, then a clean rerun.
    clr_engine();
    load({8'd3, 8'd3, 8'd7, 8'd3, 8'd1, 8'd3, 8'd7, 8'd3});
    eng_lat = 20;
    d0 = done_cnt;
    vec_base = 12'd100; weight_base = 12'h3A5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (104) @(negedge clk);
    chk("mid_steps_started", addr_n, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_result", result, 0);
    chk("mid_error", error, 0);
    chk("mid_fc_reset", fc_reset, 0);
    chk("mid_fc_start", fc_start, 0);
    chk("mid_src1", fc_src1_start_address, 0);
    chk("mid_src2", fc_src2_start_address, 0);
    repeat (40) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    clr_engine();
    run(12'd100, 12'h3A5, 400, 0, cyc);
    chk("rerun_latency", cyc, 203);
    chk("rerun_result", result, 3);
    chk("rerun_addr_step0", addr_log[0], 100);
    @(negedge clk);
    chk("rerun_done_count", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/snn_fc_vote_sequencer.md
Name: snn_fc_vote_sequencer

Overview:
- Sequences the fully connected classifier engine over NUM_STEPS spike time steps and collects one argmax class per step.
- Each step's spike vector sits at vec_base + step*STEP_STRIDE in vector memory; the weight matrix base is the same for every step.
- Keeps a per-class vote histogram and reports the majority class as the network's final classification.
- Sits between the top-level inference control (start/done) and the FC engine's start/done/result port.

Parameters:
- NUM_STEPS, 8: time steps per inference (1..255).
- NUM_CLASSES, 10: valid class indices 0..NUM_CLASSES-1.
- STEP_STRIDE, 507: vector-memory words per time step.
- ADDR_W, 12: address width.
- TIMEOUT, 8191: max cycles in WAIT (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin inference; sampled only in IDLE
- vec_base  in  ADDR_W  vector address of step 0; latched on accepted start
- weight_base  in  ADDR_W  weight matrix address; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result valid
- result  out  8  winning class; held until the next accepted start
- error  out  1  watchdog abort flag; held until the next accepted start
- fc_reset  out  1  one-cycle synchronous clear of the FC engine before each step
- fc_start  out  1  one-cycle FC engine start
- fc_src1_start_address  out  ADDR_W  vector base for the current step
- fc_src2_start_address  out  ADDR_W  weight base
- fc_done  in  1  FC engine completion (level, sticky until fc_reset)
- fc_result  in  8  FC engine argmax class

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, vote counters 0, step 0.
- Reset mid-operation: abandon the inference; no done pulse is issued.
- FSM states: IDLE, ENG_RST, ENG_START, WAIT, TALLY, DECIDE, FIN.
- IDLE:
  - On start=1: latch vec_base and weight_base, clear all votes, step=0, fc_src1_start_address=vec_base, result=0, error=0, go to ENG_RST.
  - start is ignored in every other state.
- ENG_RST: fc_reset=1 for this one cycle, then ENG_START.
- ENG_START: fc_start=1 for this one cycle, then WAIT. fc_src1/src2 addresses are stable from ENG_RST through WAIT.
- WAIT:
  - fc_done is ignored until the second WAIT cycle, which guards against a stale done.
  - On the first fc_done=1 after that, capture fc_result and go to TALLY.
- TALLY (1 cycle):
  - If the captured class < NUM_CLASSES, increment votes[class]; otherwise no vote is cast.
  - Vote counters are 8-bit saturating.
  - step+1; fc_src1_start_address += STEP_STRIDE, modulo 2^ADDR_W, using an accumulating adder with no multiplier.
  - If step+1 == NUM_STEPS go to DECIDE, else go to ENG_RST.
- DECIDE:
  - Sequential scan, one class per cycle, NUM_CLASSES cycles.
  - Strictly-greater compare, so ties resolve to the lowest index.
  - All votes zero gives result=0.
- FIN: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- A start asserted in the FIN cycle is not accepted; it is sampled in the following IDLE cycle.
- Latency per step: 3 cycles + engine time + 1.
- Total latency: NUM_STEPS*(4+engine) + NUM_CLASSES + 1 cycles from start to done.

Optional Feature:
- Macro: SNN_SEQ_WATCHDOG_EN.
- Defined:
  - A WAIT-cycle counter aborts after TIMEOUT cycles without fc_done.
  - On abort: error=1, result=8'hFF, skip DECIDE, go straight to FIN (done still pulses); fc_reset pulses once on abort.
- Undefined: WAIT waits indefinitely and error is tied to 0.

Test Plan:
- Happy path: NUM_STEPS=8, vec_base=0, engine model returns 3,3,7,3,1,3,7,3 with 20-cycle latency -> result=3, done pulses once, start-to-done = 8*24+10+1 = 203 cycles.
- Addressing: vec_base=100, STEP_STRIDE=507 -> fc_src1_start_address per step is 100, 607, 1114, ..., 3649. With vec_base=4000, step 1 -> (4000+507) mod 4096 = 411.
- Tie and out-of-range: results 2,5,2,5,9,9,12,12 -> result=2 (ties resolve low); class 12 casts no vote.
- Stale done: fc_done held high from the previous run into the next WAIT -> not captured before the second WAIT cycle; a start during busy is ignored.
- Reset mid-WAIT at step 4 -> next cycle all outputs 0, FSM IDLE, no done pulse; a new start re-runs cleanly from step 0.
- With SNN_SEQ_WATCHDOG_EN and TIMEOUT=50, engine never completes -> error=1, result=8'hFF, done pulses after 50 WAIT cycles.
